// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmit/receive blocks.
//   DATA_BITS            payload width (fixed at 8)
//   CLKS_PER_BIT_DEFAULT default clocks per serial bit (12 MHz / 115200)
//   IDLE_LEVEL           serial line level when no frame is in flight
//   uart_state_t         frame sequencing states (3-bit encoding)
package uart_pkg;

    localparam int   DATA_BITS            = 8;
    localparam int   CLKS_PER_BIT_DEFAULT = 104;
    localparam logic IDLE_LEVEL           = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt -- bit-period divider shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 and wraps; tick is high for the single cycle the
// count sits at terminal count.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset (count = 0)
//   clr    synchronous clear, restarts the bit period from 0
//   tick   one-cycle pulse at terminal count
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TC = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || (cnt == TC)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == TC);

endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core -- 8-bit UART transmitter, 8N1, LSB first, valid/ready input.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit (8E1 framing).
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   ena       wrapper enable; when low no new frame is accepted
//   tx_data   byte to send, latched on the accepting edge
//   tx_valid  producer has a byte
//   tx_ready  core accepts a byte this cycle (registered)
//   tx        serial line, idles high
//   busy      frame in progress (registered, aligned with tx)
//
// state  | meaning
// IDLE   | line high, tx_ready follows ena, waiting for a handshake
// START  | start bit (low) for one bit period
// DATA   | shift[0] on the line, eight bit periods
// PARITY | even parity of the latched byte (UART_TX_PARITY_EN only)
// STOP   | stop bit (high) for one bit period, then back to IDLE
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    uart_state_t          state;
    logic [DATA_BITS-1:0] shift;
    logic [2:0]           bit_cnt;
    logic                 tick;
    logic                 baud_clr;
    logic                 hs;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    // tx_ready is only ever high in IDLE, so it alone qualifies the handshake.
    assign hs = tx_valid && tx_ready;

    // Holding the divider clear in IDLE makes START begin a full bit period
    // on the accepting edge; the tick clear restarts each following state.
    assign baud_clr = (state == IDLE) || tick;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (baud_clr),
        .tick  (tick)
    );

    // Outputs are assigned from the state being entered, so tx/busy/tx_ready
    // change on the same edge as the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= IDLE_LEVEL;
            tx_ready   <= 1'b0;
            busy       <= 1'b0;
            shift      <= '0;
            bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        state      <= START;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                        tx_ready   <= 1'b0;
                        shift      <= tx_data;
                        bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^tx_data;
`endif
                    end else begin
                        tx       <= IDLE_LEVEL;
                        busy     <= 1'b0;
                        tx_ready <= ena;
                    end
                end
                START: begin
                    if (tick) begin
                        state <= DATA;
                        tx    <= shift[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
                            tx      <= parity_bit;
`else
                            state   <= STOP;
                            tx      <= IDLE_LEVEL;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= {1'b0, shift[DATA_BITS-1:1]};
                            tx      <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        tx    <= IDLE_LEVEL;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        state    <= IDLE;
                        tx       <= IDLE_LEVEL;
                        busy     <= 1'b0;
                        tx_ready <= ena;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx       <= IDLE_LEVEL;
                    busy     <= 1'b0;
                    tx_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
module tb_uart_tx_core;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;

    int vectors;
    int miscompares;

    uart_tx_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference frame: start(0), data LSB first, [even parity], stop(1).
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        logic [7:0] v;
        v = d;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return v[idx-1];
        if (NBITS == 11 && idx == 9) return ^v;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // Waits for the accepting edge; returns number of edges consumed.
    task automatic wait_hs(output int cycles);
        logic rdy;
        cycles = 0;
        for (int i = 0; i < 30; i++) begin
            rdy = tx_ready;
            tick1();
            cycles++;
            if (rdy && tx_valid) begin
                chk("handshake", 8'd1, 8'd1);
                return;
            end
        end
        chk("handshake_timeout", 8'd0, 8'd1);
    endtask

    // Called right after the accepting edge. Checks ncyc cycles of the frame;
    // a full frame is followed by the idle-state check.
    task automatic check_frame(input logic [7:0] d, input bit hold, input int ncyc,
                               input int ena_drop_at);
        if (!hold) tx_valid = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            chk($sformatf("tx_%02h_c%0d", d, k), 8'(tx), 8'(frame_bit(d, k / CPB)));
            chk($sformatf("busy_%02h_c%0d", d, k), 8'(busy), 8'd1);
            chk($sformatf("rdy_%02h_c%0d", d, k), 8'(tx_ready), 8'd0);
            if (k == ena_drop_at) ena = 1'b0;
            tick1();
        end
        if (ncyc == FRAME) begin
            chk($sformatf("idle_tx_%02h", d), 8'(tx), 8'd1);
            chk($sformatf("idle_busy_%02h", d), 8'(busy), 8'd0);
            chk($sformatf("idle_rdy_%02h", d), 8'(tx_ready), 8'(ena));
        end
    endtask

    task automatic send(input logic [7:0] d);
        int cyc;
        tx_data  = d;
        tx_valid = 1'b1;
        wait_hs(cyc);
        check_frame(d, 1'b0, FRAME, -1);
    endtask

    initial begin
        int cyc;
        logic [7:0] d;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        ena         = 1'b1;
        tx_valid    = 1'b1;
        tx_data     = 8'h5A;

        // Reset held with tx_valid high
        for (int i = 0; i < 5; i++) begin
            tick1();
            chk("rst_tx", 8'(tx), 8'd1);
            chk("rst_busy", 8'(busy), 8'd0);
            chk("rst_rdy", 8'(tx_ready), 8'd0);
        end
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        chk("rdy_at_release", 8'(tx_ready), 8'd0);
        tick1();
        chk("rdy_after_release", 8'(tx_ready), 8'd1);

        // Single byte
        send(8'hA5);

        // Parity-relevant byte (odd popcount)
        send(8'h07);

        // Back-to-back with tx_valid held
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        wait_hs(cyc);
        tx_data = 8'hFF;
        check_frame(8'h00, 1'b1, FRAME, -1);
        wait_hs(cyc);
        chk("b2b_idle_cycles", 8'(cyc), 8'd1);
        check_frame(8'hFF, 1'b0, FRAME, -1);

        // ena dropped during data bit 3 of 0x3C
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        wait_hs(cyc);
        check_frame(8'h3C, 1'b0, FRAME, 4 * CPB + 1);
        tx_valid = 1'b1;
        for (int i = 0; i < 3 * CPB; i++) begin
            tick1();
            chk("noena_tx", 8'(tx), 8'd1);
            chk("noena_busy", 8'(busy), 8'd0);
            chk("noena_rdy", 8'(tx_ready), 8'd0);
        end
        tx_valid = 1'b0;
        ena      = 1'b1;
        tick1();
        chk("rdy_ena_back", 8'(tx_ready), 8'd1);

        // Reset during data bit 5
        d        = 8'($urandom_range(0, 255));
        tx_data  = d;
        tx_valid = 1'b1;
        wait_hs(cyc);
        check_frame(d, 1'b0, 6 * CPB + 2, -1);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", 8'(tx), 8'd1);
        chk("midrst_busy", 8'(busy), 8'd0);
        chk("midrst_rdy", 8'(tx_ready), 8'd0);
        tick1();
        tick1();
        rst_n = 1'b1;
        tick1();
        chk("rdy_after_midrst", 8'(tx_ready), 8'd1);
        send(8'h81);

        // Random bytes with random idle gaps
        for (int n = 0; n < 6; n++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                tx_data = 8'($urandom);
                tick1();
                chk("gap_tx", 8'(tx), 8'd1);
            end
            send(8'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
